cordic_angle_sweeper: RTL and testbench

Upstream angle sequencer for the pipelined `sine_cosine` CORDIC rotator. On a start pulse it issues one angle per clock, `count` angles in total: `start_angle`, `start_angle+step`, and so on, using 32-bit signed fraction-of-circle angles (−π..+π). It also drives the constant gain-compensated `Xin`/`Yin` vector. A valid/index token is delayed by the rotator's pipeline depth so that downstream logic knows which `Xout`/`Yout` sample belongs to which issued angle.

---
 rtl/cordic_angle_sweeper.sv | 111 +++++++++++
 tb/tb_cordic_angle_sweeper.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_angle_sweeper.sv
// Angle sequencer for the pipelined sine_cosine CORDIC rotator: issues a linear
// sweep of angles and tags each rotator output with the index of its issued angle.
module cordic_angle_sweeper #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 32,
    parameter int LATENCY     = 16,
    parameter int AMPLITUDE   = 19432
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ANGLE_WIDTH-1:0] start_angle,
    input  logic [ANGLE_WIDTH-1:0] step,
    input  logic [15:0]            count,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic [DATA_WIDTH-1:0]  Xin,
    output logic [DATA_WIDTH-1:0]  Yin,
    output logic                   angle_valid,
    output logic                   out_valid,
    output logic [15:0]            out_idx,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [ANGLE_WIDTH-1:0] step_r;
    logic [15:0]            count_r;
    logic [15:0]            issue_idx;
    logic [LATENCY-1:0]     valid_line;
    logic [LATENCY-1:0]     valid_next;
    logic [15:0]            idx_line [LATENCY];

    assign Xin        = DATA_WIDTH'(AMPLITUDE);
    assign Yin        = '0;
    assign valid_next = (valid_line << 1) | LATENCY'(angle_valid);
    assign out_valid  = valid_line[LATENCY-1];
    assign out_idx    = idx_line[LATENCY-1];

    // The {valid, index} token line mirrors the rotator pipeline depth.
    always_ff @(posedge clock) begin
        if (reset || abort) begin
            valid_line <= '0;
            for (int i = 0; i < LATENCY; i++) idx_line[i] <= '0;
        end else begin
            valid_line  <= valid_next;
            idx_line[0] <= issue_idx;
            for (int i = 1; i < LATENCY; i++) idx_line[i] <= idx_line[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            angle       <= '0;
            angle_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_r      <= '0;
            count_r     <= '0;
            issue_idx   <= '0;
        end else if (abort) begin
            state       <= IDLE;
            angle_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        step_r    <= step;
                        count_r   <= count;
                        issue_idx <= '0;
                        if (count != '0) begin
                            state       <= RUN;
                            angle       <= start_angle;
                            angle_valid <= 1'b1;
                            busy        <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue_idx == count_r - 16'd1) begin
                        state       <= DRAIN;
                        angle_valid <= 1'b0;
                    end else begin
                        angle     <= angle + step_r;
                        issue_idx <= issue_idx + 16'd1;
                    end
                end
                // Leave once the token about to shift out is the last one in flight.
                DRAIN: begin
                    if (valid_next == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_angle_sweeper.sv
// Bench for cordic_angle_sweeper: a per-cycle sweep model plus directed scenarios
// with hand-computed angles, indices and cycle offsets.
`timescale 1ns/1ps
module tb_cordic_angle_sweeper;
    localparam int LAT = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] start_angle = '0;
    logic [31:0] step = '0;
    logic [15:0] count = '0;
    logic [31:0] angle;
    logic [15:0] Xin, Yin, out_idx;
    logic        angle_valid, out_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    always #5 clock = ~clock;

    cordic_angle_sweeper #(
        .DATA_WIDTH(16), .ANGLE_WIDTH(32), .LATENCY(LAT), .AMPLITUDE(19432)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .start_angle(start_angle), .step(step), .count(count),
        .angle(angle), .Xin(Xin), .Yin(Yin), .angle_valid(angle_valid),
        .out_valid(out_valid), .out_idx(out_idx), .busy(busy), .done(done)
    );

    bit          m_ready = 0, act = 0, chk_angle = 0, chk_idx = 0;
    int          k = 0, kend = 0, mc = 0;
    logic [31:0] ms = '0, mst = '0, e_angle = '0;
    logic [15:0] e_idx = '0;
    logic        e_av = 0, e_ov = 0, e_busy = 0, e_done = 0;

    int          av_cyc[$];
    logic [31:0] av_ang[$];
    int          ov_cyc[$];
    logic [15:0] ov_idx[$];
    int          done_cyc[$];
    int          busy_n = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, ecount);
        end
    endtask

    // Sweep model: outputs follow from the edge offset k since the accepted start.
    initial forever begin
        @(posedge clock);
        ecount++;
        if (reset) begin
            act = 0; m_ready = 1;
            e_av = 0; e_ov = 0; e_busy = 0; e_done = 0;
            e_angle = '0; e_idx = '0; chk_angle = 1; chk_idx = 1;
        end else if (abort) begin
            act = 0;
            e_av = 0; e_ov = 0; e_busy = 0; e_done = 0;
            chk_angle = 0; chk_idx = 0;
        end else begin
            chk_idx = 0;
            if (act) k++;
            else if (start) begin
                act = 1; k = 0;
                ms = start_angle; mst = step; mc = int'(count);
                kend = (mc == 0) ? 0 : mc + LAT;
            end
            if (act) begin
                e_av = (k < mc);
                if (mc > 0) begin
                    e_angle = ms + mst * 32'((k < mc) ? k : mc - 1);
                    chk_angle = 1;
                end
                e_ov    = (k >= LAT) && (k - LAT < mc);
                e_idx   = 16'(k - LAT);
                chk_idx = e_ov;
                e_busy  = (mc > 0) && (k < mc + LAT);
                e_done  = (k == kend);
                if (k == kend + 1) act = 0;
            end else begin
                e_av = 0; e_ov = 0; e_busy = 0; e_done = 0;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (m_ready) begin
            checkOutput("angle_valid", 32'(angle_valid), 32'(e_av));
            checkOutput("out_valid", 32'(out_valid), 32'(e_ov));
            checkOutput("busy", 32'(busy), 32'(e_busy));
            checkOutput("done", 32'(done), 32'(e_done));
            checkOutput("Xin", 32'(Xin), 32'd19432);
            checkOutput("Yin", 32'(Yin), 32'd0);
            if (chk_angle) checkOutput("angle", angle, e_angle);
            if (chk_idx) checkOutput("out_idx", 32'(out_idx), 32'(e_idx));
            if (angle_valid) begin av_cyc.push_back(ecount); av_ang.push_back(angle); end
            if (out_valid) begin ov_cyc.push_back(ecount); ov_idx.push_back(out_idx); end
            if (done) done_cyc.push_back(ecount);
            if (busy) busy_n++;
        end
    end

    function automatic int firstOf(input int q[$]);
        return (q.size() > 0) ? q[0] : -1000;
    endfunction

    function automatic int lastOf(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1000;
    endfunction

    function automatic logic [31:0] angAt(input int i);
        return (i < av_ang.size()) ? av_ang[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] idxAt(input int i);
        return (i < ov_idx.size()) ? 32'(ov_idx[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] s, input logic [15:0] c,
                                 input bit doClear, output int t0);
        @(posedge clock);
        #2;
        if (doClear) begin
            av_cyc.delete(); av_ang.delete(); ov_cyc.delete(); ov_idx.delete();
            done_cyc.delete(); busy_n = 0;
        end
        start_angle = a; step = s; count = c; start = 1'b1;
        @(posedge clock);
        #1 t0 = ecount;
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input int limit, input string name);
        int n = 0;
        while (done_cyc.size() == 0 && n < limit) begin
            @(posedge clock);
            n++;
        end
        checkOutput(name, 32'(done_cyc.size() != 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0, tx;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        $display("[TB] reset during a sweep");
        applyStimulus(32'h0000_1000, 32'h0000_0100, 16'd50, 1, t0);
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_angle", angle, 32'd0);
        checkOutput("rst_av", 32'(angle_valid), 32'd0);
        checkOutput("rst_ov", 32'(out_valid), 32'd0);
        checkOutput("rst_idx", 32'(out_idx), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_Xin", 32'(Xin), 32'd19432);
        checkOutput("rst_Yin", 32'(Yin), 32'd0);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);

        $display("[TB] degree sweep");
        applyStimulus(32'h8000_0000, 32'd357913941, 16'd13, 1, t0);
        waitDone(60, "deg_timeout");
        repeat (3) @(posedge clock);
        checkOutput("deg_av_count", 32'(av_cyc.size()), 32'd13);
        checkOutput("deg_first_angle", angAt(0), 32'h8000_0000);
        checkOutput("deg_last_angle", angAt(12), 32'h7FFF_FFFC);
        checkOutput("deg_first_av_cycle", 32'(firstOf(av_cyc) - t0 + 1), 32'd1);
        checkOutput("deg_av_span", 32'(lastOf(av_cyc) - firstOf(av_cyc)), 32'd12);
        checkOutput("deg_ov_count", 32'(ov_cyc.size()), 32'd13);
        checkOutput("deg_ov_offset", 32'(firstOf(ov_cyc) - firstOf(av_cyc)), 32'd16);
        checkOutput("deg_idx_first", idxAt(0), 32'd0);
        checkOutput("deg_idx_last", idxAt(12), 32'd12);
        checkOutput("deg_done_cycle", 32'(firstOf(done_cyc) - t0 + 1), 32'd30);

        $display("[TB] wrap");
        applyStimulus(32'h7FFF_FFF0, 32'h0000_0020, 16'd2, 1, t0);
        waitDone(40, "wrap_timeout");
        repeat (2) @(posedge clock);
        checkOutput("wrap_av_count", 32'(av_cyc.size()), 32'd2);
        checkOutput("wrap_angle0", angAt(0), 32'h7FFF_FFF0);
        checkOutput("wrap_angle1", angAt(1), 32'h8000_0010);

        $display("[TB] zero count");
        applyStimulus(32'h1234_5678, 32'h0000_0001, 16'd0, 1, t0);
        waitDone(5, "zero_timeout");
        repeat (3) @(posedge clock);
        checkOutput("zero_done_cycle", 32'(firstOf(done_cyc) - t0 + 1), 32'd1);
        checkOutput("zero_av_count", 32'(av_cyc.size()), 32'd0);
        checkOutput("zero_ov_count", 32'(ov_cyc.size()), 32'd0);
        checkOutput("zero_busy", 32'(busy_n), 32'd0);

        $display("[TB] abort at sample 40");
        applyStimulus(32'h0000_0000, 32'h0100_0000, 16'd100, 1, t0);
        while (ecount < t0 + 40) begin
            @(posedge clock);
            #1;
        end
        #1 abort = 1'b1;
        @(posedge clock);
        #2 abort = 1'b0;
        repeat (40) @(posedge clock);
        checkOutput("abort_av_count", 32'(av_cyc.size()), 32'd41);
        checkOutput("abort_last_angle", angAt(40), 32'h2800_0000);
        checkOutput("abort_last_av", 32'(lastOf(av_cyc) - t0), 32'd40);
        checkOutput("abort_ov_count", 32'(ov_cyc.size()), 32'd25);
        checkOutput("abort_last_ov", 32'(lastOf(ov_cyc) - t0), 32'd40);
        checkOutput("abort_no_done", 32'(done_cyc.size()), 32'd0);
        applyStimulus(32'h4000_0000, 32'hFFFF_FFFF, 16'd3, 1, t0);
        waitDone(40, "post_abort_timeout");
        repeat (3) @(posedge clock);
        checkOutput("post_abort_av", 32'(av_cyc.size()), 32'd3);
        checkOutput("post_abort_angle2", angAt(2), 32'h3FFF_FFFE);
        checkOutput("post_abort_ov", 32'(ov_cyc.size()), 32'd3);
        checkOutput("post_abort_idx0", idxAt(0), 32'd0);
        checkOutput("post_abort_done", 32'(done_cyc.size()), 32'd1);

        $display("[TB] start while busy");
        applyStimulus(32'h0000_1000, 32'h0000_0010, 16'd5, 1, t0);
        applyStimulus(32'h5555_0000, 32'h0000_0777, 16'd9, 0, tx);
        repeat (6) @(posedge clock);
        applyStimulus(32'h6666_0000, 32'h0000_0333, 16'd2, 0, tx);
        waitDone(40, "busy_timeout");
        repeat (20) @(posedge clock);
        checkOutput("busy_av_count", 32'(av_cyc.size()), 32'd5);
        checkOutput("busy_angle4", angAt(4), 32'h0000_1040);
        checkOutput("busy_idx4", idxAt(4), 32'd4);
        checkOutput("busy_done_count", 32'(done_cyc.size()), 32'd1);
        checkOutput("busy_done_cycle", 32'(firstOf(done_cyc) - t0 + 1), 32'd22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
